// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time goes.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins, a tie goes to the port other than last_grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT_AUX) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares data_mem between the CPU data port and an auxiliary master, turning level
// req/ack handshakes into one-cycle memread/memwrite strobes and watching clk_stall.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_sign_mask,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_sign_mask,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t  state;
    logic        last_grant;
    logic        winner;
    logic        we_r;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic [1:0]  grant;
    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_mask;

    rr_arb2 u_rr_arb2 (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign cnt_next = cnt + 1'b1;

    // Route the winning port's request fields toward the latches.
    always_comb begin
        sel       = grant[1];
        sel_we    = sel ? p1_we        : p0_we;
        sel_addr  = sel ? p1_addr      : p0_addr;
        sel_wdata = sel ? p1_wdata     : p0_wdata;
        sel_mask  = sel ? p1_sign_mask : p0_sign_mask;
    end

    // Arbiter FSM with watchdog, request latches and registered strobes/acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= PORT_AUX;
            winner         <= PORT_CPU;
            we_r           <= 1'b0;
            cnt            <= '0;
            p0_ack         <= 1'b0;
            p0_err         <= 1'b0;
            p0_rdata       <= '0;
            p1_ack         <= 1'b0;
            p1_err         <= 1'b0;
            p1_rdata       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else begin
            p0_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p1_ack       <= 1'b0;
            p1_err       <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_clk_stall && (grant != 2'b00)) begin
                        winner         <= sel;
                        last_grant     <= sel;
                        we_r           <= sel_we;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_sign_mask  <= sel_mask;
                        mem_memread    <= ~sel_we;
                        mem_memwrite   <= sel_we;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_next;
                    if ((cnt != '0) && !mem_clk_stall) begin
                        if (!we_r) begin
                            if (winner == PORT_AUX) p1_rdata <= mem_read_data;
                            else                    p0_rdata <= mem_read_data;
                        end
                        if (winner == PORT_AUX) p1_ack <= 1'b1;
                        else                    p0_ack <= 1'b1;
                        state <= RESP;
                    end else if (cnt_next == CW'(TIMEOUT_CYCLES)) begin
                        if (winner == PORT_AUX) begin
                            p1_ack <= 1'b1;
                            p1_err <= 1'b1;
                        end else begin
                            p0_ack <= 1'b1;
                            p0_err <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a small behavioural data memory.
module tb_data_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_sign_mask, p1_sign_mask;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, mem_clk_stall;

    data_mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_sign_mask   (p0_sign_mask),
        .p0_ack         (p0_ack),
        .p0_err         (p0_err),
        .p0_rdata       (p0_rdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_sign_mask   (p1_sign_mask),
        .p1_ack         (p1_ack),
        .p1_err         (p1_err),
        .p1_rdata       (p1_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_sign_mask  (mem_sign_mask),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } iss_t;

    typedef struct {
        int          cyc;
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int strobes = 0;

    // Behavioural memory: a strobe makes stall high for the next two cycles.
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] rd_latch = 32'h0;
    int          busy = 0;
    logic        stall_force = 1'b0;

    assign mem_clk_stall = stall_force | (busy != 0);
    assign mem_read_data = rd_latch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle numbering: cycle n runs from the n-th rising edge to the next.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: service strobes and count down the busy window.
    always @(posedge clk) begin
        if (mem_memwrite) mem_store[mem_addr] = mem_write_data;
        if (mem_memread) rd_latch <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : 32'h0;
        if (mem_memread || mem_memwrite) busy <= 2;
        else if (busy != 0) busy <= busy - 1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_expect(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask, input int base,
                               input logic [31:0] rdata, input bit err, input int ack_off);
        iss_q.push_back('{cyc: base + 1, we: we, addr: addr, wdata: wdata, mask: mask});
        rsp_q.push_back('{cyc: base + ack_off, port: port, err: err, rdata: rdata});
    endtask

    task automatic set_port(input bit port, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_sign_mask = mask;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_sign_mask = mask;
        end
    endtask

    task automatic wait_ack(input bit port, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ack_timeout port%0d: got no ack, expected ack within %0d cycles", port, limit);
        end
    endtask

    task automatic apply_stimulus(input bit port, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] mask,
                                  input logic [31:0] rdata, input bit err, input int ack_off);
        bit seen;
        @(negedge clk);
        set_port(port, 1'b1, we, addr, wdata, mask);
        push_expect(port, we, addr, wdata, mask, cyc, rdata, err, ack_off);
        wait_ack(port, 40, seen);
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    task automatic check_reset_values();
        check_output("rst_p0_ack",   32'(p0_ack), 32'h0);
        check_output("rst_p0_err",   32'(p0_err), 32'h0);
        check_output("rst_p1_ack",   32'(p1_ack), 32'h0);
        check_output("rst_p1_err",   32'(p1_err), 32'h0);
        check_output("rst_memread",  32'(mem_memread), 32'h0);
        check_output("rst_memwrite", 32'(mem_memwrite), 32'h0);
        check_output("rst_p0_rdata", p0_rdata, 32'h0);
        check_output("rst_p1_rdata", p1_rdata, 32'h0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_mem_wdata", mem_write_data, 32'h0);
        check_output("rst_mem_mask", 32'(mem_sign_mask), 32'h0);
    endtask

    // Monitor: pop the scoreboard whenever the DUT strobes memory or acks a port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_memread || mem_memwrite) begin
                iss_t e;
                strobes++;
                if (mem_memread && mem_memwrite)
                    check_output("both_strobes", 32'h1, 32'h0);
                if (iss_q.size() == 0) begin
                    check_output("unexpected_strobe_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = iss_q.pop_front();
                    check_output("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    check_output("strobe_we",    32'(mem_memwrite), 32'(e.we));
                    check_output("mem_addr",     mem_addr, e.addr);
                    if (e.we) check_output("mem_wdata", mem_write_data, e.wdata);
                    check_output("mem_mask",     32'(mem_sign_mask), 32'(e.mask));
                end
            end
            if (p0_ack || p1_ack) begin
                rsp_t r;
                if (p0_ack && p1_ack)
                    check_output("both_acks", 32'h1, 32'h0);
                if (rsp_q.size() == 0) begin
                    check_output("unexpected_ack_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    r = rsp_q.pop_front();
                    check_output("ack_port",  32'(p1_ack), 32'(r.port));
                    check_output("ack_cycle", 32'(cyc), 32'(r.cyc));
                    check_output("ack_err",   32'(r.port ? p1_err : p0_err), 32'(r.err));
                    check_output("ack_rdata", r.port ? p1_rdata : p0_rdata, r.rdata);
                end
            end
            if ((p0_err && !p0_ack) || (p1_err && !p1_ack))
                check_output("err_without_ack", 32'h1, 32'h0);
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish before 20000");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        bit seen;
        int base;
        int s0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_sign_mask = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_sign_mask = 0;
        mem_store[32'h0000_4008] = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Single read from the CPU port.
        apply_stimulus(1'b0, 1'b0, 32'h0000_4008, 32'h0, 4'b1010, 32'hDEAD_BEEF, 1'b0, 5);

        // Write from the aux port; its rdata stays at the reset value.
        apply_stimulus(1'b1, 1'b1, 32'h0000_4010, 32'h0000_00A5, 4'b0000, 32'h0, 1'b0, 5);

        // Contention: both ports hold req for two transactions each, expect 0,1,0,1.
        @(negedge clk);
        base = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'h0000_4010, 32'h0, 4'b0110);
        set_port(1'b1, 1'b1, 1'b1, 32'h0000_4020, 32'h1234_5678, 4'b0010);
        push_expect(1'b0, 1'b0, 32'h0000_4010, 32'h0, 4'b0110, base,      32'h0000_00A5, 1'b0, 5);
        push_expect(1'b1, 1'b1, 32'h0000_4020, 32'h1234_5678, 4'b0010, base + 6,  32'h0, 1'b0, 5);
        push_expect(1'b0, 1'b0, 32'h0000_4010, 32'h0, 4'b0110, base + 12, 32'h0000_00A5, 1'b0, 5);
        push_expect(1'b1, 1'b1, 32'h0000_4020, 32'h1234_5678, 4'b0010, base + 18, 32'h0, 1'b0, 5);
        fork
            begin
                bit s;
                for (int k = 0; k < 2; k++) wait_ack(1'b0, 40, s);
                p0_req = 1'b0;
            end
            begin
                bit s;
                for (int k = 0; k < 2; k++) wait_ack(1'b1, 40, s);
                p1_req = 1'b0;
            end
        join

        // Watchdog: memory never releases stall after the strobe.
        @(negedge clk);
        base = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'h0000_4008, 32'h0, 4'b0000);
        push_expect(1'b0, 1'b0, 32'h0000_4008, 32'h0, 4'b0000, base, 32'h0000_00A5, 1'b1, TIMEOUT + 2);
        @(negedge clk);
        stall_force = 1'b1;
        wait_ack(1'b0, 40, seen);
        s0 = strobes;
        repeat (10) @(negedge clk);
        check_output("no_issue_while_stalled", 32'(strobes), 32'(s0));
        p0_req = 1'b0;
        stall_force = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT, then a busy memory blocks the next issue.
        @(negedge clk);
        base = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'h0000_4008, 32'h0, 4'b0000);
        push_expect(1'b0, 1'b0, 32'h0000_4008, 32'h0, 4'b0000, base, 32'h0, 1'b0, 5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        stall_force = 1'b1;
        p0_req = 1'b0;
        rsp_q.delete();
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        set_port(1'b1, 1'b1, 1'b0, 32'h0000_4020, 32'h0, 4'b0011);
        s0 = strobes;
        repeat (6) @(negedge clk);
        check_output("no_issue_into_busy_mem", 32'(strobes), 32'(s0));
        stall_force = 1'b0;
        push_expect(1'b1, 1'b0, 32'h0000_4020, 32'h0, 4'b0011, cyc, 32'h1234_5678, 1'b0, 5);
        wait_ack(1'b1, 40, seen);
        p1_req = 1'b0;

        repeat (3) @(negedge clk);
        check_output("issue_queue_drained", 32'(iss_q.size()), 32'h0);
        check_output("resp_queue_drained",  32'(rsp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single data memory between the processor data port (port 0) and a secondary master such as a DMA or debug loader (port 1). It converts each requester's level req/ack handshake into the memory's one-cycle memread/memwrite strobe plus clk_stall protocol. Arbitration is round-robin, with a watchdog on the memory stall. It sits between the requesters and data_mem; data_mem itself is unchanged.

## Interface
- TIMEOUT_CYCLES, 15: maximum WAIT cycles before the watchdog aborts the transaction (must be ≥ 4).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pN_req  in  1  request, N ∈ {0,1}; held high until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  write data.
- pN_sign_mask  in  4  size/sign code, passed to memory unchanged.
- pN_ack  out  1  one-cycle completion pulse.
- pN_err  out  1  pulses with pN_ack when the watchdog fired.
- pN_rdata  out  32  read data; valid during pN_ack on reads.
- mem_addr, mem_write_data  out  32  to data memory.
- mem_sign_mask  out  4  to data memory.
- mem_memread, mem_memwrite  out  1  request strobes.
- mem_read_data  in  32  from data memory.
- mem_clk_stall  in  1  busy flag from data memory.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Leaves only when mem_clk_stall==0 and at least one pN_req is high.
  - Single requester: that requester wins.
  - Both requesting: the port that is not last_grant wins.
  - On grant: latch addr, wdata, sign_mask, we and the port index into mem_* registers; update last_grant; go to ISSUE.
- ISSUE:
  - Exactly one cycle with mem_memread = ~we or mem_memwrite = we.
  - The other strobe is 0; both strobes are 0 in every other state.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - The first WAIT cycle ignores mem_clk_stall, because the memory's stall output has not updated yet.
  - From the second WAIT cycle, mem_clk_stall==0 means done: on reads capture mem_read_data into the winner's pN_rdata; go to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES, set the winner's err flag and go to RESP.
- RESP:
  - Winner's pN_ack = 1 (and pN_err if flagged) for exactly one cycle; then IDLE.
  - The requester must drop or change pN_req in the cycle after ack. A req still high in IDLE is treated as a new request.
- pN_rdata holds its value except on that port's read completion. Write completions and timeouts leave it unchanged.
- A requester dropping req before ack is a protocol violation. The transaction still completes and acks.
- mem_addr, mem_write_data and mem_sign_mask hold their latched values from grant until the next grant.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie), counter = 0.
  - All pN_ack, pN_err, mem_memread, mem_memwrite = 0.
  - pN_rdata, mem_addr, mem_write_data = 0; mem_sign_mask = 0.
- Latency, read or write, with a 3-cycle memory:
  - Req high in cycle 0 gives ISSUE in cycle 1.
  - mem_clk_stall is high in cycles 2–3 and low in cycle 4.
  - pN_ack is high in cycle 5.
- Back-to-back from one port: the next grant comes no earlier than cycle 6. Minimum spacing is 6 cycles per transaction.
- Simultaneous requests: grants alternate 0,1,0,1…, so neither port waits more than one transaction.
- Reset mid-operation:
  - The arbiter returns to IDLE immediately.
  - The memory's in-flight transaction is not aborted.
  - The IDLE guard on mem_clk_stall==0 prevents issuing into a busy memory.
  - The interrupted requester receives no ack and must re-request.

## Structure
- Shared package data_mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - port index constants PORT_CPU=0, PORT_AUX=1;
  - default TIMEOUT_CYCLES.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick taking req[1:0] and last_grant and returning grant[1:0].
- The FSM, watchdog counter and latches stay in the top module.

## Test plan
- Single read: p0 read at 0x4008, memory model returns 0xDEADBEEF → mem_memread high in cycle 1 only; p0_ack and p0_rdata=0xDEADBEEF in cycle 5; p1_ack stays 0.
- Write: p1 write 0x0000_00A5 to 0x4010 with sign_mask 4'b0000 → mem_memwrite one cycle with exactly those values; p1_ack in cycle 5; p1_rdata unchanged.
- Contention: p0 and p1 both hold req for 4 transactions → grant order 0,1,0,1; each ack 6 cycles apart.
- Watchdog: memory model holds mem_clk_stall=1 forever → p0_ack with p0_err=1 after TIMEOUT_CYCLES WAIT cycles; no new ISSUE while stall is high.
- Reset mid-WAIT: assert rst_n=0 in cycle 3 of a read → all outputs at reset values immediately. After release with stall still high, no ISSUE until stall drops; then a p1 request is served normally.
